// File: rtl/muldiv_pkg.sv
// Shared constants, state encoding and op decode helpers for the RV32M multiply/divide unit.
// Optional build macro: MULDIV_FAST_MUL_EN (single-cycle multiplies).
package muldiv_pkg;

    localparam int XLEN  = 32;
    localparam int ITERS = 32;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic is_rem(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

    // rs1 is treated as signed by MULH, MULHSU, DIV and REM.
    function automatic logic a_signed(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic b_signed(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the divisor if it fits.
// Purely combinational; the parent registers the remainder and quotient bit.
module muldiv_div_step
    import muldiv_pkg::*;
(
    input  logic [XLEN:0]   i_rem,
    input  logic [XLEN-1:0] i_divisor,
    input  logic            i_bit,
    output logic [XLEN:0]   o_rem,
    output logic            o_q
);

    logic [XLEN+1:0] w_shifted;
    logic [XLEN:0]   w_sub;

    assign w_shifted = {i_rem, i_bit};
    // The remainder stays below the divisor, so a successful subtract always fits in XLEN+1 bits.
    assign w_sub     = w_shifted[XLEN:0] - {1'b0, i_divisor};
    assign o_q       = (w_shifted >= {2'b00, i_divisor});
    assign o_rem     = o_q ? w_sub : w_shifted[XLEN:0];

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with start/busy/done handshake for a stalling core.
// Optional build macro: MULDIV_FAST_MUL_EN (multiplies finish in one cycle via a wide product).
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    import muldiv_pkg::*;

    state_e              r_state;
    logic [2:0]          r_op;
    logic [5:0]          r_cnt;
    logic                r_neg;
    logic [XLEN-1:0]     r_div;
    logic [2*XLEN-1:0]   r_acc;
    logic [XLEN:0]       r_rem;
    logic                r_busy;
    logic                r_done;
    logic [XLEN-1:0]     r_result;

    logic                w_a_neg;
    logic                w_b_neg;
    logic [XLEN-1:0]     w_a_mag;
    logic [XLEN-1:0]     w_b_mag;
    logic                w_sign;
    logic                w_div_zero;
    logic                w_ovf;
    logic [XLEN-1:0]     w_fast_res;

    logic [XLEN:0]       w_mul_sum;
    logic [2*XLEN-1:0]   w_mul_next;
    logic [2*XLEN-1:0]   w_mul_fix;
    logic [XLEN:0]       w_step_rem;
    logic                w_step_q;
    logic [XLEN-1:0]     w_quo_next;
    logic [XLEN-1:0]     w_quo_fix;
    logic [XLEN-1:0]     w_rem_fix;
    logic [XLEN-1:0]     w_calc_res;

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

    // Operand decode at acceptance: magnitudes, result sign and the fast-path special cases.
    assign w_a_neg    = a_signed(op) & a[XLEN-1];
    assign w_b_neg    = b_signed(op) & b[XLEN-1];
    assign w_a_mag    = w_a_neg ? -a : a;
    assign w_b_mag    = w_b_neg ? -b : b;
    assign w_sign     = is_rem(op) ? w_a_neg : (w_a_neg ^ w_b_neg);
    assign w_div_zero = is_div(op) && (b == '0);
    assign w_ovf      = ((op == OP_DIV) || (op == OP_REM)) &&
                        (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);

    always_comb begin
        w_fast_res = '0;
        if (w_div_zero) begin
            w_fast_res = is_rem(op) ? a : '1;
        end else if (w_ovf) begin
            w_fast_res = is_rem(op) ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] w_fast_prod;
    logic [XLEN-1:0]   w_fast_mul_res;

    // Sign-extending both operands to 2*XLEN makes the truncated product correct for every signedness mix.
    assign w_fast_prod    = {{XLEN{w_a_neg}}, a} * {{XLEN{w_b_neg}}, b};
    assign w_fast_mul_res = (op == OP_MUL) ? w_fast_prod[XLEN-1:0] : w_fast_prod[2*XLEN-1:XLEN];
`endif

    // Shift-add: the low half of r_acc holds the multiplier, consumed LSB first as the product shifts in.
    assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_div} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};
    assign w_mul_fix  = r_neg ? -w_mul_next : w_mul_next;

    muldiv_div_step u_div_step (
        .i_rem     (r_rem),
        .i_divisor (r_div),
        .i_bit     (r_acc[XLEN-1]),
        .o_rem     (w_step_rem),
        .o_q       (w_step_q)
    );

    assign w_quo_next = {r_acc[XLEN-2:0], w_step_q};
    assign w_quo_fix  = r_neg ? -w_quo_next : w_quo_next;
    assign w_rem_fix  = r_neg ? -w_step_rem[XLEN-1:0] : w_step_rem[XLEN-1:0];

    always_comb begin
        w_calc_res = '0;
        if (is_div(r_op)) begin
            w_calc_res = is_rem(r_op) ? w_rem_fix : w_quo_fix;
        end else if (r_op == OP_MUL) begin
            w_calc_res = w_mul_fix[XLEN-1:0];
        end else begin
            w_calc_res = w_mul_fix[2*XLEN-1:XLEN];
        end
    end

    // NOTE: every register, datapath included, clears on reset so a mid-operation abort leaves no stale state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_op     <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            r_div    <= '0;
            r_acc    <= '0;
            r_rem    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_op   <= op;
                        r_cnt  <= '0;
                        r_neg  <= w_sign;
                        r_div  <= w_b_mag;
                        r_acc  <= {{XLEN{1'b0}}, w_a_mag};
                        r_rem  <= '0;
                        r_busy <= 1'b1;
                        if (w_div_zero || w_ovf) begin
                            r_result <= w_fast_res;
                            r_done   <= 1'b1;
                            r_state  <= DONE;
`ifdef MULDIV_FAST_MUL_EN
                        end else if (!is_div(op)) begin
                            r_result <= w_fast_mul_res;
                            r_done   <= 1'b1;
                            r_state  <= DONE;
`endif
                        end else begin
                            r_state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (is_div(r_op)) begin
                        r_acc <= {r_acc[2*XLEN-1:XLEN], w_quo_next};
                        r_rem <= w_step_rem;
                    end else begin
                        r_acc <= w_mul_next;
                    end
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == 6'(ITERS - 1)) begin
                        r_result <= w_calc_res;
                        r_done   <= 1'b1;
                        r_state  <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: arithmetic reference model, per-cycle compare and directed cases.
// Honours MULDIV_FAST_MUL_EN for the expected multiply latency.
module tb_muldiv_unit;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Model of the operation in flight: accepted at edge m_c0, completing m_n edges later.
    logic        m_active = 1'b0;
    int          m_c0     = 0;
    int          m_n      = 0;
    logic [31:0] m_new    = '0;
    logic [31:0] m_hold   = '0;

    logic        exp_busy;
    logic        exp_done;
    logic [31:0] exp_res;

    muldiv_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model_res(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] sx, sy, ux, uy, p;
        int ix, iy;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        ux = {32'b0, x};
        uy = {32'b0, y};
        ix = x;
        iy = y;
        case (f)
            OP_MUL:    begin p = ux * uy; return p[31:0];  end
            OP_MULH:   begin p = sx * sy; return p[63:32]; end
            OP_MULHSU: begin p = sx * uy; return p[63:32]; end
            OP_MULHU:  begin p = ux * uy; return p[63:32]; end
            OP_DIV: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
                return ix / iy;
            end
            OP_REM: begin
                if (y == 0) return x;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
                return ix % iy;
            end
            OP_DIVU: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    // Edges from acceptance to the edge that enters DONE.
    function automatic int model_n(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        if (f[2] == 1'b0) return MUL_LAT - 1;
        if (y == 0) return 0;
        if ((f == OP_DIV || f == OP_REM) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 0;
        return 32;
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    always @(negedge clk) begin
        exp_busy = m_active && (cyc >= m_c0) && (cyc <= m_c0 + m_n);
        exp_done = m_active && (cyc == m_c0 + m_n);
        exp_res  = (m_active && (cyc >= m_c0 + m_n)) ? m_new : m_hold;
        check("busy",   32'(busy), 32'(exp_busy));
        check("done",   32'(done), 32'(exp_done));
        check("result", result,    exp_res);
    end

    // Called 2 time units after a rising edge; returns likewise aligned.
    task automatic run_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                          input bit pulse, output logic [31:0] res_seen, output int lat);
        start    = 1'b1;
        op       = f;
        a        = x;
        b        = y;
        m_c0     = cyc + 1;
        m_n      = model_n(f, x, y);
        m_new    = model_res(f, x, y);
        m_active = 1'b1;
        lat      = -1;
        res_seen = '0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            #2;
            start = 1'b0;
            if (k == 0) begin
                op = 3'($urandom);
                a  = $urandom;
                b  = $urandom;
            end
            if (done && lat < 0) begin
                lat      = cyc - m_c0 + 1;
                res_seen = result;
            end
            if (cyc > m_c0 + m_n) break;
            if ((pulse && (k == 3 || cyc == m_c0 + m_n)) || $urandom_range(0, 7) == 0) start = 1'b1;
        end
        start    = 1'b0;
        m_hold   = m_new;
        m_active = 1'b0;
    endtask

    task automatic directed(input string name, input logic [2:0] f, input logic [31:0] x,
                            input logic [31:0] y, input logic [31:0] exp_lit, input int exp_lat);
        logic [31:0] res;
        int lat;
        check({name, " model"}, model_res(f, x, y), exp_lit);
        run_op(f, x, y, 1'b1, res, lat);
        check({name, " result"}, res, exp_lit);
        check({name, " latency"}, 32'(lat), 32'(exp_lat));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] res;
        int lat;
        reset = 1'b1;
        start = 1'b0;
        op    = '0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        #2;
        check("reset busy",   32'(busy), 32'd0);
        check("reset done",   32'(done), 32'd0);
        check("reset result", result,    32'd0);
        reset = 1'b0;
        @(posedge clk);
        #2;

        directed("MUL",      OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
        directed("MULH",     OP_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, MUL_LAT);
        directed("MULHU",    OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
        directed("MULHSU",   OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT);
        directed("DIV",      OP_DIV,    32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFA, 33);
        directed("REM",      OP_REM,    32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFE, 33);
        directed("DIVU",     OP_DIVU,   32'd20,         32'd3,         32'd6,         33);
        directed("REMU",     OP_REMU,   32'd20,         32'd3,         32'd2,         33);
        directed("DIV by 0", OP_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 1);
        directed("REM by 0", OP_REM,    32'd5,          32'd0,         32'd5,         1);
        directed("DIVU by0", OP_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 1);
        directed("DIV ovf",  OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
        directed("REM ovf",  OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1);
        directed("DIVU pre", OP_DIVU,   32'd20,         32'd3,         32'd6,         33);

        // Abort a DIVU after its tenth iteration; outputs must clear without a clock edge.
        start    = 1'b1;
        op       = OP_DIVU;
        a        = 32'd100;
        b        = 32'd7;
        m_c0     = cyc + 1;
        m_n      = 32;
        m_new    = 32'd14;
        m_active = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        check("pre-abort busy", 32'(busy), 32'd1);
        reset    = 1'b1;
        m_active = 1'b0;
        m_hold   = '0;
        #1;
        check("abort busy",   32'(busy), 32'd0);
        check("abort done",   32'(done), 32'd0);
        check("abort result", result,    32'd0);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        @(posedge clk);
        #2;
        directed("DIVU after abort", OP_DIVU, 32'd100, 32'd7, 32'd14, 33);

        for (int i = 0; i < 150; i++) begin
            logic [2:0]  f;
            logic [31:0] x, y;
            f = 3'($urandom);
            x = rand_operand();
            y = rand_operand();
            run_op(f, x, y, ($urandom_range(0, 3) == 0), res, lat);
            check("random latency", 32'(lat), 32'(model_n(f, x, y) + 1));
        end

        repeat (3) @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
